rx_buffer_drain_arb: RTL and testbench
======================================

Name: rx_buffer_drain_arb

Overview:
- Round-robin scheduler that drains NUM_CH two-word receive lane buffers onto one shared output register.
- Each lane buffer raises a valid pulse only while its wait input is low. The block therefore polls lanes by releasing exactly one wait line per cycle and capturing whatever word that lane presents.
- Sits between the per-lane rx buffers and the downstream word consumer. Also collects per-lane overflow indications into sticky status flags.

Parameters:
- NUM_CH, 4, number of lane buffers served (2..16).
- CH_BITS, 2, width of channel index; must satisfy 2**CH_BITS >= NUM_CH.
- WIDTH, 400, data word width per lane.

Ports:
- clk  input  1  clock; all logic on rising edge.
- arst  input  1  reset, synchronous, active-high.
- ch_data  input  NUM_CH*WIDTH  lane words; lane i occupies bits [i*WIDTH +: WIDTH].
- ch_valid  input  NUM_CH  per-lane fresh-word pulse (lane buffer dout_valid).
- ch_overflow  input  NUM_CH  per-lane overflow pulse from the lane buffer.
- ch_wait  output  NUM_CH  per-lane wait; high holds the lane's word back.
- ch_enable  input  NUM_CH  lane enable mask; disabled lanes are never polled.
- out_data  output  WIDTH  captured word.
- out_chan  output  CH_BITS  source lane of out_data.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accepts out_data this cycle.
- ovf_flags  output  NUM_CH  sticky per-lane overflow flags.
- proto_err  output  1  sticky: valid seen from a lane whose wait was high.
- clear_flags  input  1  clears ovf_flags and proto_err.

Behaviour:
- Reset (arst=1 at a clk edge) takes priority over all other activity and may occur mid-operation. It forces:
  - ptr=0, out_valid=0, out_data=0, out_chan=0.
  - ch_wait=all ones, ovf_flags=0, proto_err=0.
  - Any word held in the output register is discarded.
- can_accept = !out_valid | out_ready.
- cur = the first enabled lane at or after ptr, searching cyclically ptr, ptr+1, ..., NUM_CH-1, 0, ...
  - If no lane is enabled: all ch_wait high, ptr unchanged, no capture.
- ch_wait is combinational from registered state plus out_ready/ch_enable:
  - ch_wait[cur]=0 iff can_accept and a lane is enabled.
  - Every other bit is 1.
  - At most one bit is ever low.
- Capture: if ch_wait[cur]=0 and ch_valid[cur]=1 in the same cycle, then at the next edge out_data<=lane cur word, out_chan<=cur, out_valid<=1.
  - Zero added latency from lane valid to register load; out_valid rises one cycle after the lane pulse.
- Drain: out_valid & out_ready & no capture -> out_valid<=0. Simultaneous drain and capture -> register reloads and out_valid stays 1, giving back-to-back words at full rate.
- Pointer advance: whenever a poll occurs (ch_wait[cur]=0), ptr<=cur+1, wrapping NUM_CH-1 -> 0. This happens whether or not a word was captured, so each lane gets at most one word per visit (strict fairness).
- Stall: when can_accept=0, all waits stay high and ptr holds. Lanes keep their words; any lane overflow is reported via ch_overflow.
- ch_enable changes take effect the same cycle. Disabling the currently polled lane moves the poll to the next enabled lane.
- ovf_flags[i] <= ovf_flags[i] | ch_overflow[i] each cycle.
- proto_err <= 1 if any ch_valid[i]=1 while ch_wait[i]=1.
- clear_flags=1 zeroes both flags at the next edge. A pulse arriving in the same cycle as clear_flags wins, so the flag is set.
- Lane index arithmetic is done in CH_BITS bits with explicit wrap at NUM_CH; NUM_CH need not be a power of two.

Test Plan:
- Reset release, NUM_CH=4, all lanes enabled, no valids, out_ready=1 -> ch_wait cycles 1110,1101,1011,0111,1110 (bit0 = lane0); out_valid stays 0.
- Lanes 1 and 3 each present one word (0xA1, 0xA3), out_ready=1 -> out_chan 1 then 3 in successive outputs, out_data 0xA1 then 0xA3, each out_valid one cycle after the lane pulse.
- All lanes continuously valid, out_ready=1 -> one word per cycle; out_chan sequence 0,1,2,3,0; out_valid never drops.
- Capture word, then hold out_ready=0 for 5 cycles -> ch_wait=1111 throughout, out_data stable, ptr frozen; after out_ready=1 the poll resumes at the next lane.
- ch_enable=0101 with all lanes valid -> only lanes 0 and 2 are polled, alternating; ch_wait[1] and ch_wait[3] stay 1.
- Pulse ch_overflow[2], then clear_flags -> ovf_flags=0100, then 0000. ch_valid[0]=1 while ch_wait[0]=1 -> proto_err=1. Assert arst mid-stream -> every output returns to its reset value at the next edge.

Source files
------------

// File: rtl/rx_buffer_drain_arb.sv
// Round-robin drain of NUM_CH two-word lane buffers into one output register.
// One lane's wait line is released per cycle, and the word that lane presents
// in the same cycle is captured. Per-lane overflow pulses and protocol
// violations (valid while wait is high) are gathered into sticky flags.
//
// Handshake: the lane side is pull-style. A lane may pulse ch_valid[i] only in
// a cycle where ch_wait[i] is low, and that word is captured at the edge that
// ends the cycle. The consumer side is valid/ready. out_data/out_chan are held
// stable while out_valid=1 and out_ready=0. A word transfers at an edge where
// out_valid=1 and out_ready=1.
module rx_buffer_drain_arb #(
  parameter int NUM_CH  = 4,
  parameter int CH_BITS = 2,
  parameter int WIDTH   = 400
) (
  input  logic                    clk,
  input  logic                    arst,
  input  logic [NUM_CH*WIDTH-1:0] ch_data,
  input  logic [NUM_CH-1:0]       ch_valid,
  input  logic [NUM_CH-1:0]       ch_overflow,
  output logic [NUM_CH-1:0]       ch_wait,
  input  logic [NUM_CH-1:0]       ch_enable,
  output logic [WIDTH-1:0]        out_data,
  output logic [CH_BITS-1:0]      out_chan,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_CH-1:0]       ovf_flags,
  output logic                    proto_err,
  input  logic                    clear_flags
);

  logic [CH_BITS-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic [CH_BITS-1:0] out_chan_q, out_chan_d;
  logic               out_valid_q, out_valid_d;
  logic [NUM_CH-1:0]  ovf_q, ovf_d;
  logic               perr_q, perr_d;

  logic [CH_BITS-1:0] cur;
  logic               any_en;
  logic [CH_BITS:0]   idx_w;
  logic               can_accept;
  logic               poll;
  logic               capture;

  // Find the first enabled lane at or after ptr, wrapping at NUM_CH. The
  // descending scan lets the closest lane to ptr win.
  always_comb begin
    cur    = ptr_q;
    any_en = 1'b0;
    idx_w  = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx_w = {1'b0, ptr_q} + (CH_BITS + 1)'(k);
      if (idx_w >= (CH_BITS + 1)'(NUM_CH)) begin
        idx_w = idx_w - (CH_BITS + 1)'(NUM_CH);
      end
      if (ch_enable[idx_w[CH_BITS-1:0]]) begin
        cur    = idx_w[CH_BITS-1:0];
        any_en = 1'b1;
      end
    end
  end

  // Release one wait line, then compute capture, drain, pointer and flag updates.
  always_comb begin
    can_accept  = !out_valid_q || out_ready;
    poll        = can_accept && any_en && !arst;
    ch_wait     = '1;
    if (poll) begin
      ch_wait[cur] = 1'b0;
    end
    capture     = poll && ch_valid[cur];

    ptr_d       = ptr_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;

    if (poll) begin
      if (cur == CH_BITS'(NUM_CH - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = cur + CH_BITS'(1);
      end
    end

    if (capture) begin
      out_data_d  = ch_data[int'(cur)*WIDTH +: WIDTH];
      out_chan_d  = cur;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // A pulse in the same cycle as clear_flags survives the clear.
    if (clear_flags) begin
      ovf_d  = ch_overflow;
      perr_d = |(ch_valid & ch_wait);
    end else begin
      ovf_d  = ovf_q | ch_overflow;
      perr_d = perr_q | (|(ch_valid & ch_wait));
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (arst) begin
      ptr_q       <= '0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= '0;
      perr_q      <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
      perr_q      <= perr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;
  assign ovf_flags = ovf_q;
  assign proto_err = perr_q;

endmodule

// File: tb/tb_rx_buffer_drain_arb.sv
// Bench for rx_buffer_drain_arb: lane buffers are emulated (a lane raises
// valid only in a cycle its wait is low), and a transaction-level model with
// an expected-word queue predicts every output.
module tb_rx_buffer_drain_arb;
  localparam int NUM_CH  = 4;
  localparam int CH_BITS = 2;
  localparam int WIDTH   = 400;
  localparam int EW      = CH_BITS + WIDTH;

  // ---------------- clock / reset / DUT ----------------
  logic                    clk = 1'b0;
  logic                    arst;
  logic [NUM_CH*WIDTH-1:0] ch_data;
  logic [NUM_CH-1:0]       ch_valid, ch_overflow, ch_wait, ch_enable;
  logic [WIDTH-1:0]        out_data;
  logic [CH_BITS-1:0]      out_chan;
  logic                    out_valid, out_ready;
  logic [NUM_CH-1:0]       ovf_flags;
  logic                    proto_err, clear_flags;

  always #5 clk = ~clk;

  rx_buffer_drain_arb #(.NUM_CH(NUM_CH), .CH_BITS(CH_BITS), .WIDTH(WIDTH)) dut (
    .clk(clk), .arst(arst), .ch_data(ch_data), .ch_valid(ch_valid),
    .ch_overflow(ch_overflow), .ch_wait(ch_wait), .ch_enable(ch_enable),
    .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
    .out_ready(out_ready), .ovf_flags(ovf_flags), .proto_err(proto_err),
    .clear_flags(clear_flags)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- driver state ----------------
  logic [NUM_CH-1:0] en_v, pend_v, ovf_v, bad_v;
  logic              rdy_v, clr_v, rst_v, oneshot_v;
  logic [WIDTH-1:0]  lane_word [NUM_CH];

  // ---------------- reference model / scoreboard ----------------
  int                m_ptr;
  logic [NUM_CH-1:0] m_ovf;
  logic              m_perr;
  logic [EW-1:0]     exp_q[$];
  logic [NUM_CH-1:0] exp_wait;
  logic              exp_ov;
  logic [CH_BITS-1:0] exp_chan;
  logic [WIDTH-1:0]  exp_data;
  int                m_cur;
  logic              m_poll;

  function automatic logic [WIDTH-1:0] rand_word();
    logic [415:0] w;
    for (int j = 0; j < 13; j++) w[j*32 +: 32] = $urandom;
    return w[WIDTH-1:0];
  endfunction

  // Drive this cycle's inputs, predict the outputs, wait for the sampling edge.
  task automatic apply();
    bit can, any;
    int c;
    arst        = rst_v;
    out_ready   = rdy_v;
    ch_enable   = en_v;
    ch_overflow = ovf_v;
    clear_flags = clr_v;
    for (int i = 0; i < NUM_CH; i++) ch_data[i*WIDTH +: WIDTH] = lane_word[i];
    can   = (exp_q.size() == 0) || rdy_v;
    any   = 1'b0;
    m_cur = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      c = (m_ptr + k) % NUM_CH;
      if (!any && en_v[c]) begin
        any   = 1'b1;
        m_cur = c;
      end
    end
    m_poll   = can && any && !rst_v;
    exp_wait = '1;
    if (m_poll) exp_wait[m_cur] = 1'b0;
    ch_valid = (pend_v & ~exp_wait) | bad_v;
    exp_ov   = (exp_q.size() != 0);
    if (exp_ov) {exp_chan, exp_data} = exp_q[0];
    else        {exp_chan, exp_data} = '0;
    @(negedge clk);
  endtask

  // Advance through the active edge and update the model.
  task automatic tick();
    logic perr_now;
    @(posedge clk);
    if (rst_v) begin
      m_ptr  = 0;
      m_ovf  = '0;
      m_perr = 1'b0;
      exp_q.delete();
    end else begin
      perr_now = |(ch_valid & exp_wait);
      m_ovf    = clr_v ? ovf_v : (m_ovf | ovf_v);
      m_perr   = clr_v ? perr_now : (m_perr | perr_now);
      if (exp_q.size() != 0 && rdy_v) void'(exp_q.pop_front());
      if (m_poll && ch_valid[m_cur]) begin
        exp_q.push_back({CH_BITS'(m_cur), lane_word[m_cur]});
        if (oneshot_v) pend_v[m_cur] = 1'b0;
      end
      if (m_poll) m_ptr = (m_cur + 1) % NUM_CH;
    end
    #1;
  endtask

  task automatic defaults();
    en_v = '1; pend_v = '0; ovf_v = '0; bad_v = '0;
    rdy_v = 1'b1; clr_v = 1'b0; oneshot_v = 1'b0;
    for (int i = 0; i < NUM_CH; i++) lane_word[i] = rand_word();
  endtask

  task automatic do_reset();
    defaults();
    rst_v = 1'b1;
    apply();
    tick();
    rst_v = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    defaults();
    rst_v = 1'b1;
    apply(); tick();
    apply();
    n_vec++; if (ch_wait !== 4'b1111) begin n_err++; $display("FAIL reset_wait: got %b want 1111", ch_wait); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_vec++; if (out_data !== '0) begin n_err++; $display("FAIL reset_data: got %h want 0", out_data); end
    n_vec++; if (out_chan !== '0) begin n_err++; $display("FAIL reset_chan: got %0d want 0", out_chan); end
    n_vec++; if (ovf_flags !== '0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", ovf_flags); end
    n_vec++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL reset_perr: got %b want 0", proto_err); end
    tick();
    rst_v = 1'b0;
  endtask

  task automatic test_poll_order();
    logic [3:0] tbl [5];
    tbl[0] = 4'b1110; tbl[1] = 4'b1101; tbl[2] = 4'b1011; tbl[3] = 4'b0111; tbl[4] = 4'b1110;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      apply();
      n_vec++; if (ch_wait !== tbl[i]) begin n_err++; $display("FAIL poll_order[%0d]: got %b want %b", i, ch_wait, tbl[i]); end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL poll_idle_valid[%0d]: got %b want 0", i, out_valid); end
      tick();
    end
  endtask

  task automatic test_two_words();
    int n_seen;
    int seen_cyc [4];
    logic [CH_BITS-1:0] seen_chan [4];
    logic [WIDTH-1:0] seen_data [4];
    logic [WIDTH-1:0] w1, w3;
    do_reset();
    w1 = '0; w1[7:0] = 8'hA1;
    w3 = '0; w3[7:0] = 8'hA3;
    lane_word[1] = w1; lane_word[3] = w3;
    pend_v = 4'b1010; oneshot_v = 1'b1;
    n_seen = 0;
    for (int c = 0; c < 8; c++) begin
      apply();
      n_vec++; if (out_valid !== exp_ov) begin n_err++; $display("FAIL two_valid[%0d]: got %b want %b", c, out_valid, exp_ov); end
      if (out_valid === 1'b1 && n_seen < 4) begin
        seen_cyc[n_seen] = c; seen_chan[n_seen] = out_chan; seen_data[n_seen] = out_data;
        n_seen++;
      end
      tick();
    end
    n_vec++; if (n_seen != 2) begin n_err++; $display("FAIL two_count: got %0d want 2", n_seen); end
    if (n_seen >= 2) begin
      n_vec++; if (seen_chan[0] !== 2'd1 || seen_data[0] !== w1) begin n_err++; $display("FAIL two_first: got ch%0d %h want ch1 a1", seen_chan[0], seen_data[0][15:0]); end
      n_vec++; if (seen_chan[1] !== 2'd3 || seen_data[1] !== w3) begin n_err++; $display("FAIL two_second: got ch%0d %h want ch3 a3", seen_chan[1], seen_data[1][15:0]); end
      n_vec++; if (seen_cyc[0] != 2 || seen_cyc[1] != 4) begin n_err++; $display("FAIL two_latency: got cycles %0d,%0d want 2,4", seen_cyc[0], seen_cyc[1]); end
    end
  endtask

  task automatic test_back_to_back();
    int n_seen;
    logic [CH_BITS-1:0] seq [6];
    logic [CH_BITS-1:0] want [5];
    want[0] = 0; want[1] = 1; want[2] = 2; want[3] = 3; want[4] = 0;
    do_reset();
    pend_v = '1;
    n_seen = 0;
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < NUM_CH; i++) lane_word[i] = rand_word();
      apply();
      n_vec++; if (out_valid !== exp_ov) begin n_err++; $display("FAIL b2b_valid[%0d]: got %b want %b", c, out_valid, exp_ov); end
      if (exp_ov) begin
        n_vec++; if (out_data !== exp_data) begin n_err++; $display("FAIL b2b_data[%0d]: got %h want %h", c, out_data, exp_data); end
      end
      if (out_valid === 1'b1) begin seq[n_seen] = out_chan; n_seen++; end
      tick();
    end
    n_vec++; if (n_seen != 5) begin n_err++; $display("FAIL b2b_count: got %0d want 5", n_seen); end
    for (int i = 0; i < 5 && i < n_seen; i++) begin
      n_vec++; if (seq[i] !== want[i]) begin n_err++; $display("FAIL b2b_chan[%0d]: got %0d want %0d", i, seq[i], want[i]); end
    end
  endtask

  task automatic test_stall();
    logic [WIDTH-1:0] held;
    do_reset();
    pend_v = 4'b0001; oneshot_v = 1'b1;
    held = lane_word[0];
    apply(); tick();
    rdy_v = 1'b0;
    for (int c = 0; c < 5; c++) begin
      lane_word[0] = rand_word();
      apply();
      n_vec++; if (ch_wait !== 4'b1111) begin n_err++; $display("FAIL stall_wait[%0d]: got %b want 1111", c, ch_wait); end
      n_vec++; if (out_valid !== 1'b1 || out_chan !== 2'd0 || out_data !== held) begin
        n_err++; $display("FAIL stall_hold[%0d]: got v%b ch%0d %h want v1 ch0 %h", c, out_valid, out_chan, out_data, held); end
      tick();
    end
    rdy_v = 1'b1;
    apply();
    n_vec++; if (ch_wait !== 4'b1101) begin n_err++; $display("FAIL stall_resume: got %b want 1101", ch_wait); end
    tick();
  endtask

  task automatic test_enable_mask();
    logic [3:0] want;
    do_reset();
    en_v = 4'b0101; pend_v = '1;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < NUM_CH; i++) lane_word[i] = rand_word();
      want = (c % 2 == 0) ? 4'b1110 : 4'b1011;
      apply();
      n_vec++; if (ch_wait !== want) begin n_err++; $display("FAIL mask_wait[%0d]: got %b want %b", c, ch_wait, want); end
      if (exp_ov) begin
        n_vec++; if (out_chan !== exp_chan || out_data !== exp_data) begin
          n_err++; $display("FAIL mask_out[%0d]: got ch%0d want ch%0d", c, out_chan, exp_chan); end
      end
      tick();
    end
  endtask

  task automatic test_flags();
    do_reset();
    ovf_v = 4'b0100; apply(); tick();
    ovf_v = '0; apply();
    n_vec++; if (ovf_flags !== 4'b0100) begin n_err++; $display("FAIL ovf_set: got %b want 0100", ovf_flags); end
    tick();
    clr_v = 1'b1; apply(); tick();
    clr_v = 1'b0; apply();
    n_vec++; if (ovf_flags !== 4'b0000) begin n_err++; $display("FAIL ovf_clear: got %b want 0000", ovf_flags); end
    tick();
    ovf_v = 4'b0010; clr_v = 1'b1; apply(); tick();
    ovf_v = '0; clr_v = 1'b0; apply();
    n_vec++; if (ovf_flags !== 4'b0010) begin n_err++; $display("FAIL ovf_clear_race: got %b want 0010", ovf_flags); end
    tick();
    en_v = 4'b1110; bad_v = 4'b0001; apply();
    n_vec++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL perr_pre: got %b want 0", proto_err); end
    tick();
    bad_v = '0; apply();
    n_vec++; if (proto_err !== 1'b1) begin n_err++; $display("FAIL perr_set: got %b want 1", proto_err); end
    tick();
    clr_v = 1'b1; apply(); tick();
    clr_v = 1'b0; apply();
    n_vec++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL perr_clear: got %b want 0", proto_err); end
    tick();
    en_v = '1;
  endtask

  task automatic test_reset_mid();
    do_reset();
    en_v = 4'b0111; pend_v = '1; ovf_v = 4'b1001; bad_v = 4'b1000;
    for (int c = 0; c < 4; c++) begin apply(); tick(); end
    ovf_v = '0; bad_v = '0;
    apply();
    n_vec++; if (out_valid !== 1'b1 || proto_err !== 1'b1 || ovf_flags !== 4'b1001) begin
      n_err++; $display("FAIL mid_pre: got v%b p%b o%b want v1 p1 o1001", out_valid, proto_err, ovf_flags); end
    tick();
    rst_v = 1'b1; apply(); tick();
    rst_v = 1'b0; pend_v = '0; en_v = '1; apply();
    n_vec++; if (out_valid !== 1'b0 || out_data !== '0 || out_chan !== '0) begin
      n_err++; $display("FAIL mid_out: got v%b ch%0d want v0 ch0 data0", out_valid, out_chan); end
    n_vec++; if (ovf_flags !== '0 || proto_err !== 1'b0) begin
      n_err++; $display("FAIL mid_flags: got o%b p%b want 0 0", ovf_flags, proto_err); end
    n_vec++; if (ch_wait !== 4'b1110) begin n_err++; $display("FAIL mid_wait: got %b want 1110", ch_wait); end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      en_v   = NUM_CH'($urandom_range(0, 15));
      rdy_v  = ($urandom_range(0, 3) != 0);
      pend_v = NUM_CH'($urandom_range(0, 15));
      ovf_v  = ($urandom_range(0, 9) == 0) ? NUM_CH'($urandom_range(1, 15)) : '0;
      clr_v  = ($urandom_range(0, 19) == 0);
      bad_v  = ($urandom_range(0, 29) == 0) ? NUM_CH'($urandom_range(1, 15)) : '0;
      for (int i = 0; i < NUM_CH; i++) lane_word[i] = rand_word();
      apply();
      n_vec++; if (ch_wait !== exp_wait) begin n_err++; $display("FAIL rnd_wait[%0d]: got %b want %b", c, ch_wait, exp_wait); end
      n_vec++; if (out_valid !== exp_ov) begin n_err++; $display("FAIL rnd_valid[%0d]: got %b want %b", c, out_valid, exp_ov); end
      if (exp_ov) begin
        n_vec++; if (out_chan !== exp_chan || out_data !== exp_data) begin
          n_err++; $display("FAIL rnd_out[%0d]: got ch%0d %h want ch%0d %h", c, out_chan, out_data[31:0], exp_chan, exp_data[31:0]); end
      end
      n_vec++; if (ovf_flags !== m_ovf || proto_err !== m_perr) begin
        n_err++; $display("FAIL rnd_flags[%0d]: got o%b p%b want o%b p%b", c, ovf_flags, proto_err, m_ovf, m_perr); end
      tick();
    end
  endtask

  initial begin
    m_ptr = 0; m_ovf = '0; m_perr = 1'b0;
    rst_v = 1'b1;
    defaults();
    test_reset();
    test_poll_order();
    test_two_words();
    test_back_to_back();
    test_stall();
    test_enable_mask();
    test_flags();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
